// File: rtl/isa_pkg.sv
// rtl/isa_pkg.sv - shared ISA constants: opcodes, word field positions, command codes, issuer states
package isa_pkg;

    localparam logic [4:0] OP_NONE      = 5'b00000;
    localparam logic [4:0] OP_MAC       = 5'b00001;
    localparam logic [4:0] OP_SEND_WT   = 5'b00010;
    localparam logic [4:0] OP_STORE_OUT = 5'b00011;
    localparam logic [4:0] OP_RECV_INP  = 5'b00100;
    localparam logic [4:0] OP_RECV_WT   = 5'b00101;
    localparam logic [4:0] OP_XMIT_OUT  = 5'b00110;
    localparam logic [4:0] OP_ACC_RST   = 5'b00111;
    localparam logic [4:0] OP_NOP       = 5'b11111;

    localparam int OPC_MSB  = 63;
    localparam int OPC_LSB  = 59;
    localparam int ADDR_MSB = 58;
    localparam int ADDR_LSB = 43;
    localparam int DATA_MSB = 42;
    localparam int DATA_LSB = 27;

    localparam logic [2:0] CMD_MAC       = 3'd0;
    localparam logic [2:0] CMD_SEND_WT   = 3'd1;
    localparam logic [2:0] CMD_STORE_OUT = 3'd2;
    localparam logic [2:0] CMD_LOAD_INP  = 3'd3;
    localparam logic [2:0] CMD_LOAD_WT   = 3'd4;
    localparam logic [2:0] CMD_XMIT_OUT  = 3'd5;
    localparam logic [2:0] CMD_ACC_RESET = 3'd6;
    localparam logic [2:0] CMD_RSVD      = 3'd7;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_GAP} state_t;
    typedef enum logic [1:0] {K_SINGLE, K_BURST, K_LOAD, K_NONE} cmd_kind_t;

    function automatic logic [4:0] cmd_opcode(input logic [2:0] op);
        case (op)
            CMD_MAC:       return OP_MAC;
            CMD_SEND_WT:   return OP_SEND_WT;
            CMD_STORE_OUT: return OP_STORE_OUT;
            CMD_LOAD_INP:  return OP_RECV_INP;
            CMD_LOAD_WT:   return OP_RECV_WT;
            CMD_XMIT_OUT:  return OP_XMIT_OUT;
            CMD_ACC_RESET: return OP_ACC_RST;
            default:       return OP_NONE;
        endcase
    endfunction

    function automatic cmd_kind_t cmd_kind(input logic [2:0] op);
        case (op)
            CMD_MAC, CMD_SEND_WT, CMD_ACC_RESET: return K_SINGLE;
            CMD_STORE_OUT, CMD_XMIT_OUT:         return K_BURST;
            CMD_LOAD_INP, CMD_LOAD_WT:           return K_LOAD;
            default:                             return K_NONE;
        endcase
    endfunction

endpackage

// File: rtl/instr_pack.sv
// rtl/instr_pack.sv - combinational packer: opcode, address, data -> 64-bit instruction word
module instr_pack
    import isa_pkg::*;
(
    input  logic [4:0]  opcode,
    input  logic [15:0] addr,
    input  logic [15:0] data,
    output logic [63:0] word
);

    always_comb begin
        word                     = '0;
        word[OPC_MSB:OPC_LSB]    = opcode;
        word[ADDR_MSB:ADDR_LSB]  = addr;
        word[DATA_MSB:DATA_LSB]  = data;
    end

endmodule

// File: rtl/instr_issuer.sv
// rtl/instr_issuer.sv - command-to-instruction issuer; INSTR_ISSUER_GAP_NOP_EN adds a NOP gap after each command
module instr_issuer
    import isa_pkg::*;
#(
    parameter int CNT_W  = 8,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_base,
    input  logic [CNT_W-1:0]  cmd_len,
    input  logic              dat_valid,
    output logic              dat_ready,
    input  logic [DATA_W-1:0] dat_in,
    output logic [63:0]       instruction,
    output logic              busy,
    output logic              cmd_done
);

`ifdef INSTR_ISSUER_GAP_NOP_EN
    localparam state_t ST_AFTER = ST_GAP;
`else
    localparam state_t ST_AFTER = ST_IDLE;
`endif

    state_t            state_q, state_d;
    cmd_kind_t         kind;
    logic [2:0]        op_q;
    logic [ADDR_W-1:0] base_q;
    logic [CNT_W-1:0]  len_q, cnt_q, cnt_d;
    logic [63:0]       instr_d;
    logic              done_d;
    logic              last_beat;
    logic [4:0]        pk_opc;
    logic [ADDR_W-1:0] pk_addr;
    logic [DATA_W-1:0] pk_data;
    logic [63:0]       pk_word;

    assign kind      = cmd_kind(op_q);
    assign last_beat = (cnt_q == len_q);
    assign busy      = (state_q != ST_IDLE);

    // Packer operands kept apart from the FSM block so its output never feeds back into it
    always_comb begin
        pk_opc  = cmd_opcode(op_q);
        pk_addr = base_q + ADDR_W'(cnt_q);
        pk_data = '0;
        if (state_q != ST_ISSUE) begin
            pk_opc  = OP_NOP;
            pk_addr = '0;
        end else if (kind == K_SINGLE) begin
            pk_addr = '0;
        end else if (kind == K_LOAD) begin
            pk_data = dat_in;
        end
    end

    instr_pack u_pack (
        .opcode (pk_opc),
        .addr   (pk_addr),
        .data   (pk_data),
        .word   (pk_word)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        instr_d   = '0;
        done_d    = 1'b0;
        cmd_ready = 1'b0;
        dat_ready = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                cnt_d     = '0;
                if (cmd_valid) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                case (kind)
                    K_SINGLE: begin
                        instr_d = pk_word;
                        done_d  = 1'b1;
                        state_d = ST_AFTER;
                    end
                    K_BURST: begin
                        instr_d = pk_word;
                        cnt_d   = cnt_q + CNT_W'(1);
                        if (last_beat) begin
                            done_d  = 1'b1;
                            state_d = ST_AFTER;
                        end
                    end
                    K_LOAD: begin
                        dat_ready = 1'b1;
                        // Missing data beat issues a zero bubble and holds the beat index
                        if (dat_valid) begin
                            instr_d = pk_word;
                            cnt_d   = cnt_q + CNT_W'(1);
                            if (last_beat) begin
                                done_d  = 1'b1;
                                state_d = ST_AFTER;
                            end
                        end
                    end
                    default: begin
                        done_d  = 1'b1;
                        state_d = ST_AFTER;
                    end
                endcase
            end
`ifdef INSTR_ISSUER_GAP_NOP_EN
            ST_GAP: begin
                instr_d = pk_word;
                state_d = ST_IDLE;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            instruction <= '0;
            cmd_done    <= 1'b0;
            op_q        <= '0;
            base_q      <= '0;
            len_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            instruction <= instr_d;
            cmd_done    <= done_d;
            if (cmd_ready && cmd_valid) begin
                op_q   <= cmd_op;
                base_q <= cmd_base;
                len_q  <= cmd_len;
            end
        end
    end

endmodule
